// File: rtl/sine_sched_pkg.sv
// Shared types and helpers for the time-multiplexed sine voice scheduler.
// Holds the FSM state enum, LUT/mix widths and the quarter-wave fold.
package sine_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int LUT_AW = 6;
  localparam int LUT_DW = 9;
  localparam int MIX_W  = 12;

  typedef struct packed {
    logic              neg;
    logic [LUT_AW-1:0] addr;
  } fold_t;

  // Top phase bit selects the negative half; the next one mirrors the index.
  function automatic fold_t quad_fold(input logic [7:0] msb);
    fold_t f;
    f.neg = msb[7];
    if (msb[6]) begin
      f.addr = 6'd63 - msb[5:0];
    end else begin
      f.addr = msb[5:0];
    end
    return f;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider: one-cycle tick every SAMPLE_DIV clocks,
// first tick SAMPLE_DIV-1 cycles after reset release.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 250
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] PRE_CNT  = CW'(SAMPLE_DIV - 2);

  logic [CW-1:0] cnt_r;

  // Wrapping counter; tick is registered one count early so it lines up with LAST_CNT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (cnt_r == PRE_CNT);
      cnt_r <= (cnt_r == LAST_CNT) ? '0 : cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/sine_voice_scheduler.sv
// Shares one quarter-wave sine LUT among NUM_VOICES DDS voices and mixes them.
// Optional feature: define SINE_SCHED_OVERRUN_EN to add the sticky overrun output.
module sine_voice_scheduler
  import sine_sched_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24,
  parameter int SAMPLE_DIV = 250
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ftw_wr,
  input  logic [1:0]               ftw_sel,
  input  logic [PHASE_W-1:0]       ftw_data,
  input  logic [NUM_VOICES-1:0]    voice_en,
  output logic [LUT_AW-1:0]        lut_addr,
  input  logic [LUT_DW-1:0]        lut_sin,
  output logic signed [MIX_W-1:0]  sample_out,
  output logic                     sample_valid,
  output logic                     busy
`ifdef SINE_SCHED_OVERRUN_EN
  ,
  output logic                     overrun
`endif
);

  localparam logic [1:0] LAST_V = 2'(NUM_VOICES - 1);

  state_t                   state_r;
  logic [1:0]               v_r;
  logic                     neg_r;
  logic signed [MIX_W-1:0]  mix_r;
  logic [PHASE_W-1:0]       phase_r [4];
  logic [PHASE_W-1:0]       ftw_r   [4];
  logic                     tick_s;
  logic [3:0]               en_s;
  logic signed [MIX_W-1:0]  contrib_s;
  fold_t                    fold_s;

  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick_s)
  );

  assign busy   = (state_r != IDLE);
  assign fold_s = quad_fold(phase_r[v_r][PHASE_W-1 -: 8]);

  // Voice enables widened to the fixed 4-slot voice table.
  always_comb begin
    en_s = 4'b0000;
    en_s[NUM_VOICES-1:0] = voice_en;
  end

  // Signed contribution of the current voice from the LUT magnitude.
  always_comb begin
    contrib_s = '0;
    if (en_s[v_r]) begin
      if (neg_r) begin
        contrib_s = -$signed({{(MIX_W-LUT_DW){1'b0}}, lut_sin});
      end else begin
        contrib_s = $signed({{(MIX_W-LUT_DW){1'b0}}, lut_sin});
      end
    end else begin
      contrib_s = '0;
    end
  end

  // Frame sequencer: address / accumulate per voice, then publish the mix.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      v_r          <= 2'd0;
      neg_r        <= 1'b0;
      mix_r        <= '0;
      lut_addr     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        phase_r[i] <= '0;
        ftw_r[i]   <= '0;
      end
`ifdef SINE_SCHED_OVERRUN_EN
      overrun      <= 1'b0;
`endif
    end else begin
      // ACC below reads the old ftw, so a same-cycle write lands next frame.
      if (ftw_wr && (ftw_sel <= LAST_V)) begin
        ftw_r[ftw_sel] <= ftw_data;
      end
      sample_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (tick_s) begin
            state_r <= ADDR;
            v_r     <= 2'd0;
          end
        end
        ADDR: begin
          lut_addr <= fold_s.addr;
          neg_r    <= fold_s.neg;
          state_r  <= ACC;
        end
        ACC: begin
          mix_r        <= mix_r + contrib_s;
          phase_r[v_r] <= en_s[v_r] ? (phase_r[v_r] + ftw_r[v_r]) : '0;
          if (v_r == LAST_V) begin
            state_r <= OUT;
          end else begin
            v_r     <= v_r + 2'd1;
            state_r <= ADDR;
          end
        end
        OUT: begin
          sample_out   <= mix_r;
          mix_r        <= '0;
          sample_valid <= 1'b1;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
`ifdef SINE_SCHED_OVERRUN_EN
      if (tick_s && (state_r != IDLE)) begin
        overrun <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Bench for sine_voice_scheduler: two instances (4 voices / div 10, 2 voices / div 4)
// checked each cycle against a frame-level reference model, plus literal spot checks.
module tb_sine_voice_scheduler;

  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [23:0] data = 24'd0;
  logic [3:0] en_a = 4'b0000;
  logic [1:0] en_b = 2'b00;

  logic [5:0] la_a, la_b;
  logic [8:0] ls_a, ls_b;
  logic signed [11:0] so_a, so_b;
  logic sv_a, sv_b, busy_a, busy_b;
  logic ovr_a, ovr_b;

  int lut_tab [64];
  int n_tests = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  bit cap_on = 1'b0;
  int cap_q [$];

  // reference model state, index 0 = instance A, 1 = instance B
  int          m_cyc  [2];
  int          m_ft   [2];
  logic [23:0] m_ph   [2][4];
  logic [23:0] m_fw   [2][4];
  int          m_mix  [2];
  int          m_out  [2];
  int          m_val  [2];
  int          m_addr [2];
  int          m_ovr  [2];

  always #5 clk = ~clk;

  assign ls_a = 9'(lut_tab[la_a]);
  assign ls_b = 9'(lut_tab[la_b]);

  sine_voice_scheduler #(.NUM_VOICES(4), .PHASE_W(24), .SAMPLE_DIV(10)) dut_a (
    .clk(clk), .rst(rst), .ftw_wr(wr), .ftw_sel(sel), .ftw_data(data),
    .voice_en(en_a), .lut_addr(la_a), .lut_sin(ls_a), .sample_out(so_a),
    .sample_valid(sv_a), .busy(busy_a)
`ifdef SINE_SCHED_OVERRUN_EN
    , .overrun(ovr_a)
`endif
  );

  sine_voice_scheduler #(.NUM_VOICES(2), .PHASE_W(24), .SAMPLE_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .ftw_wr(wr), .ftw_sel(sel), .ftw_data(data),
    .voice_en(en_b), .lut_addr(la_b), .lut_sin(ls_b), .sample_out(so_b),
    .sample_valid(sv_b), .busy(busy_b)
`ifdef SINE_SCHED_OVERRUN_EN
    , .overrun(ovr_b)
`endif
  );

`ifndef SINE_SCHED_OVERRUN_EN
  assign ovr_a = 1'b0;
  assign ovr_b = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fold_addr(input logic [23:0] p);
    int q, idx;
    q = int'(p[23:22]);
    idx = int'(p[21:16]);
    return (q % 2 == 1) ? 63 - idx : idx;
  endfunction

  // Frame-level model: offset from the accepted tick decides which voice is served.
  task automatic model_step(input int i, input int nv, input int div, input logic r,
                            input logic w, input logic [1:0] s, input logic [23:0] d,
                            input logic [3:0] en);
    int c, off, v, mag;
    bit busy_now;
    if (r) begin
      for (int k = 0; k < 4; k++) begin
        m_ph[i][k] = 24'd0;
        m_fw[i][k] = 24'd0;
      end
      m_mix[i] = 0; m_out[i] = 0; m_val[i] = 0; m_addr[i] = 0; m_ovr[i] = 0;
      m_ft[i] = -1; m_cyc[i] = 0;
    end else begin
      c = m_cyc[i];
      off = (m_ft[i] >= 0) ? c - m_ft[i] : -1;
      m_val[i] = 0;
      if (off >= 1 && off <= 2 * nv - 1 && off % 2 == 1) begin
        v = (off - 1) / 2;
        m_addr[i] = fold_addr(m_ph[i][v]);
      end
      if (off >= 2 && off <= 2 * nv && off % 2 == 0) begin
        v = (off - 2) / 2;
        if (en[v]) begin
          mag = lut_tab[fold_addr(m_ph[i][v])];
          m_mix[i] += m_ph[i][v][23] ? -mag : mag;
          m_ph[i][v] = m_ph[i][v] + m_fw[i][v];
        end else begin
          m_ph[i][v] = 24'd0;
        end
      end
      busy_now = (off >= 1);
      if (off == 2 * nv + 1) begin
        m_out[i] = m_mix[i];
        m_mix[i] = 0;
        m_val[i] = 1;
        m_ft[i] = -1;
      end
      if (c % div == div - 1) begin
        if (busy_now) m_ovr[i] = 1;
        else m_ft[i] = c;
      end
      if (w && int'(s) < nv) m_fw[i][s] = d;
      m_cyc[i] = c + 1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 4, 10, rst, wr, sel, data, en_a);
    model_step(1, 2, 4, rst, wr, sel, data, {2'b00, en_b});
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_valid", int'(sv_a), m_val[0]);
      chk("a_sample", int'(so_a), m_out[0]);
      chk("a_busy", int'(busy_a), (m_ft[0] >= 0) ? 1 : 0);
      chk("a_addr", int'(la_a), m_addr[0]);
      chk("b_valid", int'(sv_b), m_val[1]);
      chk("b_sample", int'(so_b), m_out[1]);
      chk("b_busy", int'(busy_b), (m_ft[1] >= 0) ? 1 : 0);
      chk("b_addr", int'(la_b), m_addr[1]);
`ifdef SINE_SCHED_OVERRUN_EN
      chk("a_overrun", int'(ovr_a), m_ovr[0]);
      chk("b_overrun", int'(ovr_b), m_ovr[1]);
`endif
      if (cap_on && sv_a) cap_q.push_back(int'(so_a));
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr_ftw(input logic [1:0] s, input logic [23:0] d);
    wr = 1'b1; sel = s; data = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic capture(input int n, input int budget);
    int k = 0;
    cap_q.delete();
    cap_on = 1'b1;
    while (cap_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    cap_on = 1'b0;
    chk("capture_count", cap_q.size() >= n ? n : cap_q.size(), n);
  endtask

  initial begin
    int k, b, nvalid;
    for (int a = 0; a < 64; a++) lut_tab[a] = $rtoi(511.0 * $sin(a * PI / 126.0) + 1.0e-6);

    // silent voice: all-zero output, first valid at SAMPLE_DIV-1+10
    @(negedge clk);
    do_reset(3);
    chk_on = 1'b1;
    en_a = 4'b0001; en_b = 2'b01;
    k = 0;
    while (!sv_a && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("first_valid_cycle", k, 19);
    chk("silent_sample", int'(so_a), 0);

    // single voice sweeping one LUT step per sample
    do_reset(2);
    en_a = 4'b0001;
    wr_ftw(2'd0, 24'h010000);
    capture(257, 2700);
    chk("k0", cap_q[0], 0);
    chk("k1", cap_q[1], 12);
    chk("k2", cap_q[2], 25);
    chk("k64", cap_q[64], 511);
    chk("k128", cap_q[128], 0);
    chk("k192", cap_q[192], -511);
    chk("k256", cap_q[256], 0);

    // four voices in phase, then drop and re-enable voice 2
    do_reset(2);
    en_a = 4'b0000; en_b = 2'b00;
    for (int v = 0; v < 4; v++) wr_ftw(2'(v), 24'h010000);
    en_a = 4'b1111; en_b = 2'b11;
    capture(193, 2100);
    chk("quad_k64", cap_q[64], 2044);
    chk("quad_k192", cap_q[192], -2044);
    en_a[2] = 1'b0;
    repeat (35) @(negedge clk);
    en_a[2] = 1'b1;
    repeat (35) @(negedge clk);

    // ftw write to voice 1 in its ACC cycle; also out-of-range select on instance B
    repeat (3) begin
      k = 0;
      while (!((m_cyc[0] % 10) == 3 && m_ft[0] >= 0) && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("acc_align", (k < 50) ? 1 : 0, 1);
      wr_ftw(2'd1, 24'($urandom_range(1, 1 << 20)));
      wr_ftw(2'd3, 24'($urandom));
      repeat (12) @(negedge clk);
    end
`ifdef SINE_SCHED_OVERRUN_EN
    chk("b_overrun_sticky", int'(ovr_b), 1);
`endif

    // reset in the middle of a frame
    k = 0;
    while (!(m_ft[0] >= 0 && m_cyc[0] - m_ft[0] == 5) && k < 50) begin
      @(negedge clk);
      k++;
    end
    do_reset(1);
    chk("mid_rst_valid", int'(sv_a), 0);
    chk("mid_rst_sample", int'(so_a), 0);
    chk("mid_rst_busy", int'(busy_a), 0);
    nvalid = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (sv_a) nvalid++;
    end
    chk("mid_rst_no_valid", nvalid, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      wr = ($urandom_range(0, 7) == 0);
      sel = 2'($urandom_range(0, 3));
      data = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($urandom_range(0, 1 << 18));
      if ($urandom_range(0, 29) == 0) begin
        b = $urandom_range(0, 3);
        en_a[b] = ~en_a[b];
      end
      if ($urandom_range(0, 29) == 0) begin
        b = $urandom_range(0, 1);
        en_b[b] = ~en_b[b];
      end
      rst = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    wr = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
